// File: rtl/sc_phase_pkg.sv
// Shared types and helpers for the two-phase switched-capacitor clock controller.
// Holds the FSM state encoding, latched mode encodings and the channel rotation search.
package sc_phase_pkg;

    localparam int MAX_CH   = 32;
    localparam int MAX_CH_W = $clog2(MAX_CH);

    typedef enum logic [2:0] {
        IDLE,
        PH1,
        DEAD_A,
        PH2,
        DEAD_B,
        DONE
    } phase_state_t;

    localparam logic [1:0] MODE_CONT  = 2'd0;
    localparam logic [1:0] MODE_BURST = 2'd1;
    localparam logic [1:0] MODE_ILV   = 2'd2;

    // Next set bit strictly after cur, wrapping at nch-1; returns cur when no other bit is set.
    function automatic int unsigned next_set_bit(input logic [MAX_CH-1:0] mask,
                                                 input int unsigned cur,
                                                 input int unsigned nch);
        int unsigned idx;
        int unsigned res;
        logic        found;
        res   = cur;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_CH; k++) begin
            if (!found && k <= nch) begin
                idx = cur + k;
                if (idx >= nch) begin
                    idx = idx - nch;
                end
                if (mask[idx[MAX_CH_W-1:0]]) begin
                    res   = idx;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sc_phase_timer.sv
// Loadable down-counter shared by the phase and dead-time intervals.
// The next count is exported so the controller can register its outputs one cycle ahead.
module sc_phase_timer
    import sc_phase_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count_nxt,
    output logic         tc
);

    logic [W-1:0] count_q;

    always_comb begin
        count_nxt = count_q;
        if (load) begin
            count_nxt = load_val;
        end else if (count_q != '0) begin
            count_nxt = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_nxt;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/sc_phase_ctrl.sv
// Non-overlapping two-phase clock and switch controller for multi-channel SC filter arrays.
// Every output is a flop loaded from the decoded next state so the switch drivers never see glitches.
module sc_phase_ctrl
    import sc_phase_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int CNT_W   = 8,
    parameter int DEAD_W  = 4,
    parameter int BURST_W = 8,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [CNT_W-1:0]   half_len,
    input  logic [DEAD_W-1:0]  dead_len,
    input  logic [BURST_W-1:0] burst_n,
    input  logic [NCH-1:0]     ch_mask,
    input  logic               az_req,
    output logic               busy,
    output logic               done,
    output logic [NCH-1:0]     phi1,
    output logic [NCH-1:0]     phi1d,
    output logic [NCH-1:0]     phi2,
    output logic [NCH-1:0]     phi2d,
    output logic               az,
    output logic               sample_stb,
    output logic [CH_W-1:0]    ch_idx
);

    localparam int TW = (CNT_W > DEAD_W) ? CNT_W : DEAD_W;
    localparam int SW = BURST_W + 1;

    phase_state_t       state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   half_q, half_d, h_in;
    logic [DEAD_W-1:0]  dead_q, dead_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [NCH-1:0]     mask_q, mask_d;
    logic               azreq_q, azreq_d;
    logic               first_q, first_d;
    logic               stop_q, stop_d;
    logic [SW-1:0]      scnt_q, scnt_d;
    logic [CH_W-1:0]    ch_d;
    logic               load;
    logic [TW-1:0]      load_val;
    logic [TW-1:0]      cnt_nxt;
    logic               tc;

    logic               busy_d, done_d, az_d, stb_d;
    logic [NCH-1:0]     vec, phi1_d, phi1d_d, phi2_d, phi2d_d;

    sc_phase_timer #(.W(TW)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_val  (load_val),
        .count_nxt (cnt_nxt),
        .tc        (tc)
    );

    // A zero half_len would leave no room for phi1 inside phi1d, so H is held at 2 minimum.
    assign h_in = (half_len == '0) ? CNT_W'(1) : half_len;

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = TW'(half_q);
        mode_d   = mode_q;
        half_d   = half_q;
        dead_d   = dead_q;
        burst_d  = burst_q;
        mask_d   = mask_q;
        azreq_d  = azreq_q;
        first_d  = first_q;
        scnt_d   = scnt_q;
        ch_d     = ch_idx;
        stop_d   = (state_q == IDLE) ? 1'b0 : (stop_q | stop);
        case (state_q)
            IDLE: begin
                if (start && ch_mask != '0) begin
                    state_d  = PH1;
                    load     = 1'b1;
                    load_val = TW'(h_in);
                    mode_d   = (mode == 2'd3) ? MODE_CONT : mode;
                    half_d   = h_in;
                    dead_d   = dead_len;
                    burst_d  = burst_n;
                    mask_d   = ch_mask;
                    azreq_d  = az_req;
                    first_d  = 1'b1;
                    scnt_d   = '0;
                    ch_d     = (mode == MODE_ILV)
                             ? CH_W'(next_set_bit(MAX_CH'(ch_mask), NCH - 1, NCH))
                             : '0;
                end
            end
            PH1: begin
                if (tc) begin
                    state_d  = DEAD_A;
                    load     = 1'b1;
                    load_val = TW'(dead_q);
                    first_d  = 1'b0;
                end
            end
            DEAD_A: begin
                if (tc) begin
                    state_d = PH2;
                    load    = 1'b1;
                end
            end
            PH2: begin
                if (tc) begin
                    state_d  = DEAD_B;
                    load     = 1'b1;
                    load_val = TW'(dead_q);
                    scnt_d   = scnt_q + 1'b1;
                end
            end
            DEAD_B: begin
                if (tc) begin
                    if (stop_d || (mode_q == MODE_BURST && scnt_q == SW'(burst_q) + 1'b1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = PH1;
                        load    = 1'b1;
                        if (mode_q == MODE_ILV) begin
                            ch_d = CH_W'(next_set_bit(MAX_CH'(mask_q), 32'(ch_idx), NCH));
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d == IDLE) begin
            ch_d = '0;
        end
    end

    // Outputs are decoded from the state and count about to be registered, so they line up with the FSM.
    always_comb begin
        vec     = (mode_d == MODE_ILV) ? (NCH'(1) << ch_d) : mask_d;
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        stb_d   = (state_q == PH2) && (state_d == DEAD_B);
        phi1_d  = '0;
        phi1d_d = '0;
        phi2_d  = '0;
        phi2d_d = '0;
        if (state_d == PH1) begin
            phi1d_d = vec;
            phi1_d  = (cnt_nxt != '0) ? vec : '0;
        end
        if (state_d == PH2) begin
            phi2d_d = vec;
            phi2_d  = (cnt_nxt != '0) ? vec : '0;
        end
        az_d = azreq_d && first_d && (state_d == PH1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= MODE_CONT;
            half_q     <= '0;
            dead_q     <= '0;
            burst_q    <= '0;
            mask_q     <= '0;
            azreq_q    <= 1'b0;
            first_q    <= 1'b0;
            stop_q     <= 1'b0;
            scnt_q     <= '0;
            ch_idx     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            az         <= 1'b0;
            sample_stb <= 1'b0;
            phi1       <= '0;
            phi1d      <= '0;
            phi2       <= '0;
            phi2d      <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            half_q     <= half_d;
            dead_q     <= dead_d;
            burst_q    <= burst_d;
            mask_q     <= mask_d;
            azreq_q    <= azreq_d;
            first_q    <= first_d;
            stop_q     <= stop_d;
            scnt_q     <= scnt_d;
            ch_idx     <= ch_d;
            busy       <= busy_d;
            done       <= done_d;
            az         <= az_d;
            sample_stb <= stb_d;
            phi1       <= phi1_d;
            phi1d      <= phi1d_d;
            phi2       <= phi2_d;
            phi2d      <= phi2d_d;
        end
    end

endmodule

// File: tb/tb_sc_phase_ctrl.sv
// Directed bench for sc_phase_ctrl: a cycle-accurate expected trace is queued at each start
// and popped against the registered outputs on every falling clock edge.
module tb_sc_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, az_req;
    logic [1:0] mode;
    logic [7:0] half_len, burst_n;
    logic [3:0] dead_len, ch_mask;
    logic       busy, done, az, sample_stb;
    logic [3:0] phi1, phi1d, phi2, phi2d;
    logic [1:0] ch_idx;
    logic [21:0] obs;

    logic [21:0] sb[$];
    int tests = 0;
    int fails = 0;
    int stbCount = 0;
    int doneCount = 0;

    always #5 clk = ~clk;

    sc_phase_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .half_len   (half_len),
        .dead_len   (dead_len),
        .burst_n    (burst_n),
        .ch_mask    (ch_mask),
        .az_req     (az_req),
        .busy       (busy),
        .done       (done),
        .phi1       (phi1),
        .phi1d      (phi1d),
        .phi2       (phi2),
        .phi2d      (phi2d),
        .az         (az),
        .sample_stb (sample_stb),
        .ch_idx     (ch_idx)
    );

    assign obs = {busy, done, az, sample_stb, ch_idx, phi1, phi1d, phi2, phi2d};

    function automatic logic [21:0] mkRec(input logic b, input logic d, input logic a, input logic s,
                                          input logic [1:0] ch, input logic [3:0] p1,
                                          input logic [3:0] p1d, input logic [3:0] p2,
                                          input logic [3:0] p2d);
        return {b, d, a, s, ch, p1, p1d, p2, p2d};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        logic [21:0] exp;
        @(negedge clk);
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            checkOutput("trace", 32'(obs), 32'(exp));
        end
        checkOutput("no_overlap", {24'd0, phi1d & phi2d, phi1 & phi2}, 32'd0);
        if (sample_stb) stbCount++;
        if (done) doneCount++;
    endtask

    // Expected per-cycle behaviour for nper full periods, then DONE and one idle cycle.
    task automatic buildTrace(input int md, input int hl, input int dl, input logic [3:0] mask,
                              input logic azr, input int nper);
        int h;
        int d;
        int ch;
        int chs[$];
        logic [3:0] vec;
        h  = (hl + 1 < 2) ? 2 : hl + 1;
        d  = dl + 1;
        ch = 0;
        for (int i = 0; i < 4; i++) if (mask[i]) chs.push_back(i);
        for (int p = 0; p < nper; p++) begin
            ch  = (md == 2) ? chs[p % chs.size()] : 0;
            vec = (md == 2) ? (4'b0001 << ch) : mask;
            for (int i = 0; i < h; i++)
                sb.push_back(mkRec(1, 0, azr && p == 0, 0, 2'(ch), (i < h - 1) ? vec : 4'h0, vec, 4'h0, 4'h0));
            for (int i = 0; i < d; i++)
                sb.push_back(mkRec(1, 0, 0, 0, 2'(ch), 4'h0, 4'h0, 4'h0, 4'h0));
            for (int i = 0; i < h; i++)
                sb.push_back(mkRec(1, 0, 0, 0, 2'(ch), 4'h0, 4'h0, (i < h - 1) ? vec : 4'h0, vec));
            for (int i = 0; i < d; i++)
                sb.push_back(mkRec(1, 0, 0, i == 0, 2'(ch), 4'h0, 4'h0, 4'h0, 4'h0));
        end
        sb.push_back(mkRec(1, 1, 0, 0, 2'(ch), 4'h0, 4'h0, 4'h0, 4'h0));
        sb.push_back(22'd0);
    endtask

    task automatic applyStimulus(input logic [1:0] md, input logic [7:0] hl, input logic [3:0] dl,
                                 input logic [3:0] mask, input logic azr, input logic [7:0] bn);
        mode     = md;
        half_len = hl;
        dead_len = dl;
        ch_mask  = mask;
        az_req   = azr;
        burst_n  = bn;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        mode     = 2'($urandom);
        half_len = 8'($urandom);
        dead_len = 4'($urandom);
        ch_mask  = 4'($urandom);
        az_req   = 1'($urandom);
        burst_n  = 8'($urandom);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 2000) begin
            tick();
            guard++;
        end
        checkOutput(tag, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        mode     = 2'd0;
        half_len = 8'd0;
        dead_len = 4'd0;
        ch_mask  = 4'd0;
        az_req   = 1'b0;
        burst_n  = 8'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset_state", 32'(obs), 32'd0);
        rst_n = 1'b1;
        tick();

        // Continuous, H=4 D=2, autozero, stray start while busy, stop in second PH1.
        doneCount = 0;
        buildTrace(0, 3, 1, 4'hF, 1'b1, 2);
        applyStimulus(2'd0, 8'd3, 4'd1, 4'hF, 1'b1, 8'd0);
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain("cont_drain");
        checkOutput("cont_done_count", 32'(doneCount), 32'd1);
        checkOutput("cont_idle_busy", 32'(busy), 32'd0);

        // Burst of five samples.
        stbCount  = 0;
        doneCount = 0;
        buildTrace(1, 2, 2, 4'b0101, 1'b0, 5);
        applyStimulus(2'd1, 8'd2, 4'd2, 4'b0101, 1'b0, 8'd4);
        drain("burst_drain");
        checkOutput("burst_stb_count", 32'(stbCount), 32'd5);
        checkOutput("burst_done_count", 32'(doneCount), 32'd1);
        checkOutput("burst_idle_busy", 32'(busy), 32'd0);

        // Interleaved over channels 1 and 3 with half_len clamped, stop in fourth PH1.
        buildTrace(2, 0, 0, 4'b1010, 1'b0, 4);
        applyStimulus(2'd2, 8'd0, 4'd0, 4'b1010, 1'b0, 8'd0);
        repeat (18) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain("ilv_drain");

        // Empty channel mask must not start anything.
        repeat (3) sb.push_back(22'd0);
        applyStimulus(2'd0, 8'd3, 4'd1, 4'h0, 1'b1, 8'd0);
        repeat (2) tick();
        checkOutput("mask0_busy", 32'(busy), 32'd0);
        sb.delete();

        // Asynchronous reset while PH2 is active.
        buildTrace(0, 3, 1, 4'hF, 1'b0, 1);
        applyStimulus(2'd0, 8'd3, 4'd1, 4'hF, 1'b0, 8'd0);
        repeat (7) tick();
        sb.delete();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_phases", {15'd0, phi1, phi1d, phi2, phi2d, az}, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) sb.push_back(22'd0);
        repeat (3) tick();
        checkOutput("post_rst_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sc_phase_ctrl.md
Name: sc_phase_ctrl

Overview:
- Parametrised two-phase, non-overlapping clock and switch controller for multi-channel switched-capacitor filter arrays built around the cascode current-mirror OTA cell.
- Generates per-channel phi1/phi2 and their delayed copies phi1d/phi2d for bottom-plate sampling, with programmable phase length and dead time.
- Supports three modes: continuous, burst (N samples), and round-robin interleaved channels.
- Sits between the digital sequencer and the analog switch drivers.

Parameters:
- NCH, 4, number of filter channels.
- CNT_W, 8, width of phase-length field.
- DEAD_W, 4, width of dead-time field.
- BURST_W, 8, width of burst sample count.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a sequence.
- stop  input  1  graceful stop request.
- mode  input  2  0=continuous, 1=burst, 2=interleaved, 3=reserved (treated as 0).
- half_len  input  CNT_W  phase high length minus 1, in clk cycles.
- dead_len  input  DEAD_W  dead time minus 1, in clk cycles.
- burst_n  input  BURST_W  samples per burst minus 1.
- ch_mask  input  NCH  channel enable mask.
- az_req  input  1  autozero during the first phi1 of the sequence.
- busy  output  1  sequence active.
- done  output  1  one-cycle pulse when a sequence ends.
- phi1, phi1d, phi2, phi2d  output  NCH each  switch controls.
- az  output  1  autozero switch.
- sample_stb  output  1  one-cycle pulse at each phi2d fall.
- ch_idx  output  clog2(NCH)  channel of the current cycle.

Behaviour:
- Reset: all outputs 0 (all switches open), state IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.
- FSM states: IDLE, PH1, DEAD_A, PH2, DEAD_B, DONE.
- Starting a sequence:
  - start is accepted in IDLE only when ch_mask != 0; otherwise it is ignored.
  - On acceptance, mode, half_len, dead_len, burst_n, ch_mask and az_req are latched.
  - The FSM enters PH1 and phi outputs change on the cycle after start.
  - start while busy is ignored.
- Phase timing (H = half_len+1, D = dead_len+1, with H clamped to a minimum of 2):
  - phi1 high for H-1 cycles.
  - phi1d high for H cycles, rising on the same cycle as phi1.
  - DEAD_A lasts D cycles, with all phases low.
  - phi2/phi2d in PH2 follow the same rule as phi1/phi1d in PH1.
  - DEAD_B lasts D cycles, then the FSM returns to PH1.
  - Period is 2H+2D cycles.
  - phi1d and phi2d are never high together; phi1 and phi2 are never high together.
- Channel gating:
  - Continuous and burst modes: phi bits are driven for every latched mask bit; ch_idx = 0.
  - Interleaved mode: only channel ch_idx toggles. After each DEAD_B, ch_idx advances to the next set mask bit, wrapping at NCH-1 back to the lowest set bit.
- az:
  - When az_req is latched, az equals phi1d during the first PH1 only.
- sample_stb:
  - Pulses on the cycle phi2d falls.
- Burst mode:
  - After burst_n+1 sample_stb pulses, the FSM goes through DONE, which pulses done, then IDLE.
- Stop (continuous/interleaved):
  - stop is sticky once seen while busy.
  - The current cycle completes through DEAD_B, then DONE, then IDLE.
  - stop in PH1 still finishes PH2, so no half-charged sample is left.
  - Burst mode honours stop the same way.
- busy is 1 from PH1 entry through DONE inclusive.
- Reset mid-operation: all outputs drop immediately (asynchronously), which opens all switches safely.
- Inputs other than start/stop are ignored while busy; only the latched copies are used.

Decomposition:
- Package sc_phase_pkg holds:
  - FSM state enum.
  - Mode encodings MODE_CONT, MODE_BURST, MODE_ILV.
  - Function for next-set-bit search over NCH.
- Sub-module sc_phase_timer: a loadable down-counter with a terminal-count flag. It is reused for the phase and dead intervals.

Test Plan:
- Continuous, half_len=3, dead_len=1, ch_mask=4'b1111 -> phi1 high 3 cycles, phi1d 4, dead 2, period 12; no phi1d/phi2d overlap (assertion).
- Burst, burst_n=4 -> exactly 5 sample_stb pulses, done pulses once, busy falls the cycle after done.
- Interleaved, ch_mask=4'b1010 -> ch_idx sequence 1,3,1,3; phi bits 0 and 2 stay 0.
- stop asserted mid-PH1, continuous -> PH2 and DEAD_B complete, then done, then idle; no truncated phase.
- rst_n low during PH2 -> all phi and az outputs 0 immediately; after release, busy=0 until a new start.
- Edge cases:
  - ch_mask=0 with start -> start ignored, busy stays 0.
  - half_len=0 -> clamped to H=2 (phi1 1 cycle, phi1d 2 cycles).
  - az_req=1 -> az high only during the first phi1d.
